// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file constants shared by registerFile and regfile_reader,
// the reader state type and small address/count/parity helpers.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } readerState_t;

  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(NUM_REGS - 1)) begin
      return '0;
    end else begin
      return a + ADDR_W'(1);
    end
  endfunction

  // Requests larger than the file collapse to one full pass.
  function automatic logic [CNT_W-1:0] clampCount(input logic [CNT_W-1:0] c);
    if (c > CNT_W'(NUM_REGS)) begin
      return CNT_W'(NUM_REGS);
    end else begin
      return c;
    end
  endfunction

  function automatic logic dataParity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_reader_if.sv
// regfile_reader_if: register-file read port plus the valid/ready word stream.
// outParity exists only when REGFILE_READER_PARITY_EN is defined.
interface regfile_reader_if;
  import regfile_pkg::*;

  logic [ADDR_W-1:0] rdReg;
  logic [DATA_W-1:0] rdData;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outData;
  logic [ADDR_W-1:0] outAddr;
  logic              outLast;
`ifdef REGFILE_READER_PARITY_EN
  logic              outParity;

  modport master (output rdReg, input rdData, output outValid, input outReady,
                  output outData, output outAddr, output outLast, output outParity);
  modport slave  (input rdReg, output rdData, input outValid, output outReady,
                  input outData, input outAddr, input outLast, input outParity);
`else
  modport master (output rdReg, input rdData, output outValid, input outReady,
                  output outData, output outAddr, output outLast);
  modport slave  (input rdReg, output rdData, input outValid, output outReady,
                  input outData, input outAddr, input outLast);
`endif

endinterface

// File: rtl/regfile_reader.sv
// regfile_reader: sweeps a window of register addresses through a combinational read
// port and streams {data, addr, last} over valid/ready. REGFILE_READER_PARITY_EN adds outParity.
module regfile_reader
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic [ADDR_W-1:0] firstReg,
  input  logic [CNT_W-1:0]  count,
  regfile_reader_if.master  bus,
  output logic              busy,
  output logic              done
);

  readerState_t      stateQ, stateD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [CNT_W-1:0]  remQ, remD;
  logic              validQ, validD;
  logic              lastQ, lastD;
  logic              busyQ, busyD;
  logic              doneQ, doneD;
  logic [DATA_W-1:0] dataQ, dataD;
  logic [ADDR_W-1:0] outAddrQ, outAddrD;
  logic              captureS;
`ifdef REGFILE_READER_PARITY_EN
  logic              parityQ, parityD;
`endif

  // Next-state and next-payload logic for the sweep FSM.
  always_comb begin
    stateD   = stateQ;
    addrD    = addrQ;
    remD     = remQ;
    validD   = validQ;
    lastD    = lastQ;
    busyD    = busyQ;
    doneD    = 1'b0;
    dataD    = dataQ;
    outAddrD = outAddrQ;
    captureS = 1'b0;
`ifdef REGFILE_READER_PARITY_EN
    parityD  = parityQ;
`endif
    case (stateQ)
      IDLE: begin
        if (start && (count != '0)) begin
          addrD  = firstReg;
          remD   = clampCount(count);
          busyD  = 1'b1;
          stateD = FETCH;
        end else begin
          stateD = IDLE;
        end
      end
      FETCH: begin
        captureS = 1'b1;
        stateD   = SEND;
      end
      SEND: begin
        // A non-final handshake reloads the payload on the same edge for back-to-back words.
        if (validQ && bus.outReady) begin
          if (lastQ) begin
            validD = 1'b0;
            lastD  = 1'b0;
            busyD  = 1'b0;
            doneD  = 1'b1;
            stateD = DONE;
          end else begin
            captureS = 1'b1;
            stateD   = SEND;
          end
        end else begin
          stateD = SEND;
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        validD = 1'b0;
        busyD  = 1'b0;
        stateD = IDLE;
      end
    endcase

    if (captureS) begin
      dataD    = bus.rdData;
      outAddrD = addrQ;
      lastD    = (remQ == CNT_W'(1));
      addrD    = nextAddr(addrQ);
      remD     = remQ - CNT_W'(1);
      validD   = 1'b1;
`ifdef REGFILE_READER_PARITY_EN
      parityD  = dataParity(bus.rdData);
`endif
    end else begin
      captureS = 1'b0;
    end
  end

  // State, sweep counters and the output register stage.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ   <= IDLE;
      addrQ    <= '0;
      remQ     <= '0;
      validQ   <= 1'b0;
      lastQ    <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      dataQ    <= '0;
      outAddrQ <= '0;
`ifdef REGFILE_READER_PARITY_EN
      parityQ  <= 1'b0;
`endif
    end else begin
      stateQ   <= stateD;
      addrQ    <= addrD;
      remQ     <= remD;
      validQ   <= validD;
      lastQ    <= lastD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      dataQ    <= dataD;
      outAddrQ <= outAddrD;
`ifdef REGFILE_READER_PARITY_EN
      parityQ  <= parityD;
`endif
    end
  end

  assign bus.rdReg    = addrQ;
  assign bus.outValid = validQ;
  assign bus.outData  = dataQ;
  assign bus.outAddr  = outAddrQ;
  assign bus.outLast  = lastQ;
`ifdef REGFILE_READER_PARITY_EN
  assign bus.outParity = parityQ;
`endif
  assign busy = busyQ;
  assign done = doneQ;

endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: randomized self-checking bench; expected words come from a
// snapshot of the bench's own register-file array taken when each sweep starts.
module tb_regfile_reader;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] firstReg = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rf [NUM_REGS];
  int                checks = 0;
  int                passed = 0;

  regfile_reader_if bus();

  regfile_reader dut (
    .clk      (clk),
    .rstN     (rstN),
    .start    (start),
    .firstReg (firstReg),
    .count    (count),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign bus.rdData = rf[bus.rdReg];

  task automatic test_reset();
    bus.outReady = 1'b0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.outValid, bus.outLast, busy, done} !== 4'b0000 || bus.outData !== 32'd0 ||
        bus.outAddr !== 5'd0 || bus.rdReg !== 5'd0) begin
      $display("FAIL reset_values: got v=%b l=%b busy=%b done=%b data=%h addr=%0d rdReg=%0d, expected all zero",
               bus.outValid, bus.outLast, busy, done, bus.outData, bus.outAddr, bus.rdReg);
    end else passed++;
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic doSweep(input string tag, input logic [4:0] first, input logic [5:0] cnt,
                         input int mode, input bit timed, input int wrK, input logic [4:0] wrA,
                         input int restartK);
    logic [31:0] expData[$];
    logic [4:0]  expAddr[$];
    logic [31:0] prevData;
    logic [4:0]  prevAddr;
    logic        prevLast;
    bit          prevStall;
    int          n, got, doneK, doneCount;
    n = (cnt > 6'd32) ? 32 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      expAddr.push_back(5'((int'(first) + i) % NUM_REGS));
      expData.push_back(rf[(int'(first) + i) % NUM_REGS]);
    end
    got = 0; doneK = -1; doneCount = 0; prevStall = 1'b0;
    prevData = '0; prevAddr = '0; prevLast = 1'b0;
    @(negedge clk);
    start = 1'b1; firstReg = first; count = cnt;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = (k == restartK);
      firstReg = 5'd20; count = 6'd3;
      case (mode)
        0: bus.outReady = 1'b1;
        1: bus.outReady = ((k % 3) == 1);
        default: bus.outReady = 1'($urandom_range(0, 1));
      endcase
      if (prevStall) begin
        checks++;
        if (bus.outValid !== 1'b1 || bus.outData !== prevData || bus.outAddr !== prevAddr ||
            bus.outLast !== prevLast) begin
          $display("FAIL %s stall_stable: got v=%b %h@%0d l=%b, expected v=1 %h@%0d l=%b",
                   tag, bus.outValid, bus.outData, bus.outAddr, bus.outLast, prevData, prevAddr, prevLast);
        end else passed++;
      end
      if (done === 1'b1) begin
        checks++;
        if (doneCount != 0 || got != n) begin
          $display("FAIL %s done_pulse: got done with %0d words, prior dones %0d, expected %0d words, 0 prior",
                   tag, got, doneCount, n);
        end else passed++;
        doneCount++;
        if (doneK < 0) doneK = k;
      end
      checks++;
      if (busy !== (doneK < 0)) begin
        $display("FAIL %s busy: got %b expected %b at cycle %0d", tag, busy, (doneK < 0), k);
      end else passed++;
      if (bus.outValid === 1'b1 && bus.outReady) begin
        checks++;
        if (got >= n) begin
          $display("FAIL %s extra_word: got word %0d addr %0d, expected only %0d words", tag, got, bus.outAddr, n);
        end else if (bus.outData !== expData[got] || bus.outAddr !== expAddr[got] ||
                     bus.outLast !== (got == n - 1)) begin
          $display("FAIL %s word%0d: got %h@%0d last=%b, expected %h@%0d last=%b", tag, got,
                   bus.outData, bus.outAddr, bus.outLast, expData[got], expAddr[got], (got == n - 1));
        end else passed++;
`ifdef REGFILE_READER_PARITY_EN
        if (got < n) begin
          checks++;
          if (bus.outParity !== ^expData[got]) begin
            $display("FAIL %s parity%0d: got %b expected %b", tag, got, bus.outParity, ^expData[got]);
          end else passed++;
        end
`endif
        if (timed) begin
          checks++;
          if (k != got + 1) begin
            $display("FAIL %s word_timing: word %0d at cycle %0d, expected cycle %0d", tag, got, k, got + 1);
          end else passed++;
        end
        got++;
      end
      prevStall = (bus.outValid === 1'b1) && !bus.outReady;
      prevData = bus.outData; prevAddr = bus.outAddr; prevLast = bus.outLast;
      if (k == wrK) begin
        @(posedge clk);
        rf[wrA] <= 32'hDEAD;
      end
      if (doneK >= 0 && k >= doneK + 3) break;
    end
    start = 1'b0;
    checks++;
    if (got != n || doneCount != 1) begin
      $display("FAIL %s sweep_total: got %0d words and %0d dones, expected %0d words and 1 done",
               tag, got, doneCount, n);
    end else passed++;
    if (timed) begin
      checks++;
      if (doneK != n + 1) begin
        $display("FAIL %s done_timing: got done at cycle %0d, expected %0d", tag, doneK, n + 1);
      end else passed++;
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'(i * 10);
    doSweep("basic", 5'd0, 6'd10, 0, 1'b1, -1, 5'd0, -1);
  endtask

  task automatic test_wrap();
    doSweep("wrap", 5'd30, 6'd4, 0, 1'b1, -1, 5'd0, -1);
  endtask

  task automatic test_count_zero();
    @(negedge clk);
    start = 1'b1; firstReg = 5'd7; count = 6'd0; bus.outReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, bus.outValid, done} !== 3'b000) begin
        $display("FAIL count_zero: got busy=%b valid=%b done=%b, expected 000", busy, bus.outValid, done);
      end else passed++;
    end
  endtask

  task automatic test_clamp();
    doSweep("clamp", 5'd0, 6'd40, 0, 1'b1, -1, 5'd0, -1);
  endtask

  task automatic test_stall();
    doSweep("stall", 5'($urandom_range(0, 31)), 6'd5, 1, 1'b0, -1, 5'd0, -1);
  endtask

  task automatic test_write_and_restart();
    doSweep("wr_restart", 5'd0, 6'd6, 0, 1'b1, 3, 5'd3, 2);
    checks++;
    if (rf[3] !== 32'hDEAD) begin
      $display("FAIL write_landed: got %h expected %h", rf[3], 32'hDEAD);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    logic [4:0] first;
    first = 5'($urandom_range(0, 31));
    @(negedge clk);
    start = 1'b1; firstReg = first; count = 6'd8; bus.outReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.outValid !== 1'b1 || bus.outAddr !== 5'(first + 5'd1)) begin
      $display("FAIL mid_sweep_word2: got v=%b addr=%0d, expected v=1 addr=%0d",
               bus.outValid, bus.outAddr, 5'(first + 5'd1));
    end else passed++;
    rstN = 1'b0;
    #1;
    checks++;
    if ({bus.outValid, bus.outLast, busy, done} !== 4'b0000 || bus.outData !== 32'd0 ||
        bus.outAddr !== 5'd0 || bus.rdReg !== 5'd0) begin
      $display("FAIL async_reset: got v=%b l=%b busy=%b done=%b data=%h addr=%0d, expected all zero",
               bus.outValid, bus.outLast, busy, done, bus.outData, bus.outAddr);
    end else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) rstN = 1'b1;
      checks++;
      if ({bus.outValid, done} !== 2'b00) begin
        $display("FAIL reset_no_done: got valid=%b done=%b, expected 00", bus.outValid, done);
      end else passed++;
    end
    doSweep("after_reset", 5'($urandom_range(0, 31)), 6'($urandom_range(1, 12)), 2, 1'b0, -1, 5'd0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
    for (int s = 0; s < 5; s++) begin
      doSweep("random", 5'($urandom_range(0, 31)), 6'($urandom_range(1, 63)), 2, 1'b0, -1, 5'd0, -1);
    end
    doSweep("rand_full", 5'($urandom_range(0, 31)), 6'($urandom_range(1, 63)), 0, 1'b1, -1, 5'd0, -1);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_count_zero();
    test_clamp();
    test_stall();
    test_write_and_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sequential dump engine for the 32 x 32-bit register file. On `start` it sweeps a contiguous window of register addresses through one of the register file's combinational read ports. It captures each word and streams it out over a valid/ready interface, tagged with its address. It sits beside `registerFile` as a read-port client, for debug dump, context save, and bench checking.

## Interface
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width
- `NUM_REGS`, 32, registers in the file; addresses wrap modulo this value
- `clk`  in  1  single clock, all state on rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; sampled only in IDLE
- `firstReg`  in  ADDR_W  first address of the sweep; sampled with `start`
- `count`  in  ADDR_W+1  number of registers to read; 0 = start ignored; values >32 clamp to 32
- `rdReg`  out  ADDR_W  read address to the register file port
- `rdData`  in  DATA_W  combinational read data from the register file
- `outValid`  out  1  `outData`/`outAddr`/`outLast` valid
- `outReady`  in  1  sink accepts the word when high together with `outValid`
- `outData`  out  DATA_W  captured register contents
- `outAddr`  out  ADDR_W  address the word was read from
- `outLast`  out  1  final word of the sweep
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  single-cycle pulse after the final handshake

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: `start`=1 and `count`!=0 → load `addrQ`=`firstReg`, `remQ`=min(`count`,32) → FETCH. `start` with `count`=0 does nothing.
- `rdReg` = `addrQ` at all times.
- FETCH: capture `rdData` into `outData` and `addrQ` into `outAddr`. `outLast`=(`remQ`==1). Then `addrQ`+1 mod 32, `remQ`-1 → SEND.
- SEND: hold `outValid`=1 and all payload stable until the handshake.
  - On handshake with `remQ`>0: capture the next word in the same edge and stay in SEND. This gives back-to-back throughput.
  - On handshake with `outLast`: → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- `start` during FETCH, SEND or DONE is ignored.
- Address wrap: `firstReg`=30, `count`=4 reads 30, 31, 0, 1.
- Concurrent writes: the captured value is the register contents at the capture edge. A write to the same register on that edge is not seen, because the old value is read.
- `outReady` high while `outValid`=0 has no effect.

## Timing
- Reset values: `outValid`=0, `outData`=0, `outAddr`=0, `outLast`=0, `busy`=0, `done`=0, `rdReg`=0, state=IDLE.
- Reset asserted mid-sweep clears all of the above immediately (asynchronous). The sweep is abandoned, with no `done`.
- `start` accepted at edge T → FETCH during T+1 → first `outValid` at T+2.
- `outReady` held high: N words on consecutive cycles T+2 .. T+N+1, `done` at T+N+2, `busy` low at T+N+2.
- Each stalled cycle (`outReady`=0 with `outValid`=1) adds exactly one cycle; the payload is unchanged.
- A new `start` is accepted in the cycle after `done`, i.e. back in IDLE.

## Configuration
- `REGFILE_READER_PARITY_EN` defined: adds output port `outParity` (1 bit) = XOR of `outData`. It is registered with the payload, reset 0 and held stable with it.
- Not defined: no `outParity` port; behaviour otherwise identical.

## Structure
- Shared package `regfile_pkg`: `ADDR_W`, `DATA_W`, `NUM_REGS` constants and the reader state typedef (IDLE/FETCH/SEND/DONE). `registerFile` uses the same constants.
- Single module, no sub-module; the output register stage is inline.

## Test plan
- Registers preloaded with data = index*10; `start`, `firstReg`=0, `count`=10, `outReady`=1 → words 0,10,…,90 on addrs 0–9 in 10 consecutive cycles starting 2 cycles after `start`. `outLast` on addr 9; `done` the next cycle.
- `firstReg`=30, `count`=4 → addrs 30, 31, 0, 1 with their data; `outLast` on addr 1.
- `count`=0 → no `busy`, no `outValid`, no `done`. `count`=40 → exactly 32 words, addrs 0–31 from `firstReg`=0.
- `outReady` toggled 1,0,0,1… on a 5-word sweep → payload stable during stalls, no word lost or duplicated, `done` once.
- Write 0xDEAD to reg 3 on the capture edge for addr 3 → old value streamed. Second `start` mid-sweep → ignored.
- `rstN` low during SEND of word 2 of 8 → `outValid`/`busy` drop immediately, no `done`. A subsequent sweep runs normally.
